pc_target_unit: RTL and testbench
=================================

Name: pc_target_unit

Overview:
Parametrised program-counter register plus next-PC selector for the MIPS fetch stage. Forms the J-type target by joining the upper PC+4 bits with the instruction target field. Also forms branch targets (PC+4 + offset) and register-jump targets. Holds the PC under stall, and remembers a redirect that arrives during a stall so that it is never lost.

Parameters:
ADDR_W, 32, PC/address width in bits; must be >= TGT_W+2
TGT_W, 26, jump target field width (instruction index)
IMM_W, 16, branch immediate width (word offset, signed)
RESET_PC, 32'h0000_0000 (ADDR_W bits), PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold PC this cycle
jump_valid  in  1  J-type redirect request
jump_target  in  TGT_W  instruction index field
branch_valid  in  1  taken-branch redirect request
branch_imm  in  IMM_W  signed word offset
jr_valid  in  1  register-jump redirect request
jr_target  in  ADDR_W  register value for JR
pc  out  ADDR_W  current PC (registered)
pc_plus4  out  ADDR_W  pc + 4, combinational from pc
redirect_pending  out  1  a redirect is held awaiting end of stall (registered)
misaligned  out  1  sticky: a JR target with low bits != 0 was accepted (registered)

Behaviour:
- Reset (sync, high): pc=RESET_PC, redirect_pending=0, pending target=0, misaligned=0. Reset overrides every other input in that cycle, including mid-stall and pending redirects.
- pc_plus4 = pc + 4, modulo 2^ADDR_W; it wraps, e.g. 32'hFFFF_FFFC -> 0.
- J target = {pc_plus4[ADDR_W-1:TGT_W+2], jump_target, 2'b00}.
- Branch target = pc_plus4 + (sign_extend(branch_imm) << 2), modulo 2^ADDR_W.
- JR target = {jr_target[ADDR_W-1:2], 2'b00}.
- Request priority in a cycle: jr_valid > jump_valid > branch_valid > sequential. Only the winning request is used.
- misaligned is set on any cycle where jr_valid wins and jr_target[1:0] != 0, whether or not the cycle is stalled. It clears only on reset.
- Non-stall cycle:
  - If a request is present, pc <= request target.
  - Else if redirect_pending, pc <= pending target.
  - Else pc <= pc_plus4.
  - redirect_pending <= 0 in all three cases.
  - A new same-cycle request beats a pending one; the pending target is then discarded.
- Stall cycle:
  - pc holds.
  - If a request is present, pending target <= request target and redirect_pending <= 1. A later request overwrites an earlier pending one.
  - With no request, the pending state holds.
- Latency: a redirect accepted in cycle N appears on pc in cycle N+1. A redirect arriving during a stall appears on pc one cycle after the first non-stall cycle.
- Internal state: one two-bit-free state flag (redirect_pending) plus pending target register; no further FSM.
- Elaboration check: fatal error if ADDR_W < TGT_W+2 or IMM_W+2 > ADDR_W.

Decomposition:
- Package pc_pkg:
  - enum pc_src_t {SRC_SEQ, SRC_BR, SRC_J, SRC_JR}, used for the priority mux.
  - Localparam PC_STEP=4.
- Sub-module jump_target_concat (ADDR_W, TGT_W):
  - Combinational; takes pc_plus4 and jump_target, returns the J target.
  - Instantiated once.

Test Plan:
- Reset, then 3 idle cycles with RESET_PC=0 -> pc = 0, 4, 8, C; redirect_pending=0, misaligned=0.
- pc=32'h4000_0010, jump_valid=1, jump_target=26'h0000100 -> next pc = 32'h4000_0400.
- pc=32'h0000_0100, branch_valid=1, branch_imm=16'hFFFE -> next pc = 32'h0000_00FC. Then with pc=32'hFFFF_FFFC and no request -> next pc = 0.
- stall=1 for 3 cycles; branch request (imm=4) in cycle 1, jump request in cycle 2:
  - pc holds through the stall.
  - redirect_pending=1 from cycle 2 on.
  - On the first non-stall cycle the J target loads and pending returns to 0.
- jr_valid, jump_valid and branch_valid all 1 together, jr_target=32'h0000_2003 -> pc = 32'h0000_2000, misaligned=1. misaligned stays 1 until reset.
- reset asserted while stall=1 and redirect_pending=1 -> next cycle pc=RESET_PC, redirect_pending=0, and the pending target is not applied afterwards.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage PC unit.
// Defines the redirect source enum used by the next-PC mux.
package pc_pkg;

  typedef enum logic [1:0] {
    SRC_SEQ = 2'd0,
    SRC_BR  = 2'd1,
    SRC_J   = 2'd2,
    SRC_JR  = 2'd3
  } pc_src_t;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/jump_target_concat.sv
// J-type target former: splices the instruction index
// into the region selected by the upper PC+4 bits.
module jump_target_concat #(
  parameter int ADDR_W = 32,
  parameter int TGT_W  = 26
) (
  input  logic [ADDR_W-1:0] pc_plus4_i,
  input  logic [TGT_W-1:0]  jump_target_i,
  output logic [ADDR_W-1:0] j_target_o
);

  // Low PC+4 bits are replaced by the index and word alignment.
  logic unused_low;
  assign unused_low = ^pc_plus4_i[TGT_W+1:0];

  if (ADDR_W > TGT_W + 2) begin : g_region
    assign j_target_o = {pc_plus4_i[ADDR_W-1:TGT_W+2],
                         jump_target_i, 2'b00};
  end else begin : g_full
    assign j_target_o = {jump_target_i, 2'b00};
  end

endmodule

// File: rtl/pc_target_unit.sv
// PC register and next-PC selector for the fetch stage.
// A redirect seen during a stall is parked until the stall ends.
module pc_target_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                TGT_W    = 26,
  parameter int                IMM_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              jump_valid,
  input  logic [TGT_W-1:0]  jump_target,
  input  logic              branch_valid,
  input  logic [IMM_W-1:0]  branch_imm,
  input  logic              jr_valid,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              redirect_pending,
  output logic              misaligned
);

  if (ADDR_W < TGT_W + 2 || IMM_W + 2 > ADDR_W) begin : g_bad_cfg
    $fatal(1, "pc_target_unit: bad ADDR_W/TGT_W/IMM_W");
  end

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ptgt_q, ptgt_d;
  logic              pend_q, pend_d;
  logic              mis_q, mis_d;

  logic [ADDR_W-1:0] j_tgt;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] jr_tgt;
  logic [ADDR_W-1:0] br_ext;
  logic [ADDR_W-1:0] req_tgt;
  pc_src_t           src;
  logic              req;

  assign pc_plus4 = pc_q + ADDR_W'(PC_STEP);

  jump_target_concat #(
    .ADDR_W(ADDR_W),
    .TGT_W (TGT_W)
  ) u_jcat (
    .pc_plus4_i   (pc_plus4),
    .jump_target_i(jump_target),
    .j_target_o   (j_tgt)
  );

  assign br_ext = {{(ADDR_W-IMM_W){branch_imm[IMM_W-1]}},
                   branch_imm};
  assign br_tgt = pc_plus4 + (br_ext << 2);
  assign jr_tgt = {jr_target[ADDR_W-1:2], 2'b00};

  // Pick the highest-priority request and its target.
  always_comb begin
    src     = SRC_SEQ;
    req_tgt = pc_plus4;
    if (jr_valid) begin
      src = SRC_JR;
    end else if (jump_valid) begin
      src = SRC_J;
    end else if (branch_valid) begin
      src = SRC_BR;
    end
    unique case (src)
      SRC_JR:  req_tgt = jr_tgt;
      SRC_J:   req_tgt = j_tgt;
      SRC_BR:  req_tgt = br_tgt;
      default: req_tgt = pc_plus4;
    endcase
  end

  assign req = (src != SRC_SEQ);

  // Next PC, pending-redirect bookkeeping and sticky JR misalignment.
  always_comb begin
    pc_d   = pc_q;
    ptgt_d = ptgt_q;
    pend_d = pend_q;
    mis_d  = mis_q;
    if (src == SRC_JR && jr_target[1:0] != 2'b00) begin
      mis_d = 1'b1;
    end
    if (stall) begin
      if (req) begin
        ptgt_d = req_tgt;
        pend_d = 1'b1;
      end
    end else begin
      pend_d = 1'b0;
      if (req) begin
        pc_d = req_tgt;
      end else if (pend_q) begin
        pc_d = ptgt_q;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      ptgt_q <= '0;
      pend_q <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ptgt_q <= ptgt_d;
      pend_q <= pend_d;
      mis_q  <= mis_d;
    end
  end

  assign pc               = pc_q;
  assign redirect_pending = pend_q;
  assign misaligned       = mis_q;

endmodule

// File: tb/tb_pc_target_unit.sv
// Directed bench for pc_target_unit.
// Each task drives one scenario and checks against hand-computed values.
module tb_pc_target_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        jump_valid;
  logic [25:0] jump_target;
  logic        branch_valid;
  logic [15:0] branch_imm;
  logic        jr_valid;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect_pending;
  logic        misaligned;

  int checks = 0;
  int failures = 0;

  pc_target_unit #(
    .ADDR_W  (32),
    .TGT_W   (26),
    .IMM_W   (16),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .jump_valid      (jump_valid),
    .jump_target     (jump_target),
    .branch_valid    (branch_valid),
    .branch_imm      (branch_imm),
    .jr_valid        (jr_valid),
    .jr_target       (jr_target),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .redirect_pending(redirect_pending),
    .misaligned      (misaligned)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    jump_valid   = 1'b0;
    branch_valid = 1'b0;
    jr_valid     = 1'b0;
  endtask

  task automatic load_pc(input logic [31:0] a);
    jr_valid  = 1'b1;
    jr_target = a;
    step();
    clear_req();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0);
    end
    checks++;
    if (redirect_pending !== 1'b0 || misaligned !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b%b exp=00",
               redirect_pending, misaligned);
    end
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (pc !== 32'(4 * i)) begin
        failures++;
        $display("FAIL seq_pc%0d got=%h exp=%h", i, pc, 32'(4 * i));
      end
    end
    checks++;
    if (pc_plus4 !== 32'h10 || redirect_pending !== 1'b0) begin
      failures++;
      $display("FAIL seq_plus4 got=%h/%b exp=00000010/0",
               pc_plus4, redirect_pending);
    end
  endtask

  task automatic test_jump();
    load_pc(32'h4000_0010);
    checks++;
    if (pc !== 32'h4000_0010 || pc_plus4 !== 32'h4000_0014) begin
      failures++;
      $display("FAIL jr_load got=%h/%h exp=40000010/40000014",
               pc, pc_plus4);
    end
    jump_valid  = 1'b1;
    jump_target = 26'h0000100;
    step();
    clear_req();
    checks++;
    if (pc !== 32'h4000_0400) begin
      failures++;
      $display("FAIL jump got=%h exp=%h", pc, 32'h4000_0400);
    end
  endtask

  task automatic test_branch();
    load_pc(32'h0000_0100);
    branch_valid = 1'b1;
    branch_imm   = 16'hFFFE;
    step();
    clear_req();
    checks++;
    if (pc !== 32'h0000_00FC) begin
      failures++;
      $display("FAIL branch_neg got=%h exp=%h", pc, 32'h0000_00FC);
    end
    load_pc(32'hFFFF_FFFC);
    checks++;
    if (pc_plus4 !== 32'h0) begin
      failures++;
      $display("FAIL plus4_wrap got=%h exp=0", pc_plus4);
    end
    step();
    checks++;
    if (pc !== 32'h0) begin
      failures++;
      $display("FAIL pc_wrap got=%h exp=0", pc);
    end
  endtask

  task automatic test_stall();
    load_pc(32'h1000_0000);
    stall        = 1'b1;
    branch_valid = 1'b1;
    branch_imm   = 16'h0004;
    step();
    clear_req();
    checks++;
    if (pc !== 32'h1000_0000 || redirect_pending !== 1'b1) begin
      failures++;
      $display("FAIL stall_c1 got=%h/%b exp=10000000/1",
               pc, redirect_pending);
    end
    jump_valid  = 1'b1;
    jump_target = 26'h0000040;
    step();
    clear_req();
    checks++;
    if (pc !== 32'h1000_0000 || redirect_pending !== 1'b1) begin
      failures++;
      $display("FAIL stall_c2 got=%h/%b exp=10000000/1",
               pc, redirect_pending);
    end
    step();
    checks++;
    if (pc !== 32'h1000_0000 || redirect_pending !== 1'b1) begin
      failures++;
      $display("FAIL stall_c3 got=%h/%b exp=10000000/1",
               pc, redirect_pending);
    end
    stall = 1'b0;
    step();
    checks++;
    if (pc !== 32'h1000_0100 || redirect_pending !== 1'b0) begin
      failures++;
      $display("FAIL stall_release got=%h/%b exp=10000100/0",
               pc, redirect_pending);
    end
    step();
    checks++;
    if (pc !== 32'h1000_0104) begin
      failures++;
      $display("FAIL after_release got=%h exp=10000104", pc);
    end
  endtask

  task automatic test_back_to_back();
    load_pc(32'h0000_0800);
    stall        = 1'b1;
    branch_valid = 1'b1;
    branch_imm   = 16'h0010;
    step();
    clear_req();
    stall     = 1'b0;
    jr_valid  = 1'b1;
    jr_target = 32'h0000_3000;
    step();
    clear_req();
    checks++;
    if (pc !== 32'h0000_3000 || redirect_pending !== 1'b0) begin
      failures++;
      $display("FAIL new_beats_pending got=%h/%b exp=00003000/0",
               pc, redirect_pending);
    end
    step();
    checks++;
    if (pc !== 32'h0000_3004) begin
      failures++;
      $display("FAIL pending_discarded got=%h exp=00003004", pc);
    end
  endtask

  task automatic test_jr_priority();
    jr_valid     = 1'b1;
    jr_target    = 32'h0000_2003;
    jump_valid   = 1'b1;
    jump_target  = 26'h0000300;
    branch_valid = 1'b1;
    branch_imm   = 16'h0040;
    step();
    clear_req();
    checks++;
    if (pc !== 32'h0000_2000 || misaligned !== 1'b1) begin
      failures++;
      $display("FAIL jr_priority got=%h/%b exp=00002000/1",
               pc, misaligned);
    end
    load_pc(32'h0000_4000);
    step();
    step();
    checks++;
    if (misaligned !== 1'b1 || pc !== 32'h0000_4008) begin
      failures++;
      $display("FAIL mis_sticky got=%b/%h exp=1/00004008",
               misaligned, pc);
    end
  endtask

  task automatic test_reset_pending();
    load_pc(32'h0000_0500);
    stall        = 1'b1;
    branch_valid = 1'b1;
    branch_imm   = 16'h0010;
    step();
    clear_req();
    checks++;
    if (redirect_pending !== 1'b1) begin
      failures++;
      $display("FAIL pend_before_reset got=%b exp=1",
               redirect_pending);
    end
    reset = 1'b1;
    step();
    checks++;
    if (pc !== 32'h0 || redirect_pending !== 1'b0 ||
        misaligned !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_stall got=%h/%b%b exp=00000000/00",
               pc, redirect_pending, misaligned);
    end
    reset = 1'b0;
    stall = 1'b0;
    step();
    checks++;
    if (pc !== 32'h4) begin
      failures++;
      $display("FAIL no_stale_pending got=%h exp=00000004", pc);
    end
  endtask

  task automatic test_mis_in_stall();
    stall     = 1'b1;
    jr_valid  = 1'b1;
    jr_target = 32'h0000_7001;
    step();
    clear_req();
    checks++;
    if (misaligned !== 1'b1 || pc !== 32'h4) begin
      failures++;
      $display("FAIL mis_stalled got=%b/%h exp=1/00000004",
               misaligned, pc);
    end
    stall = 1'b0;
    step();
    checks++;
    if (pc !== 32'h0000_7000 || redirect_pending !== 1'b0) begin
      failures++;
      $display("FAIL jr_from_pending got=%h/%b exp=00007000/0",
               pc, redirect_pending);
    end
  endtask

  initial begin
    reset        = 1'b1;
    stall        = 1'b0;
    jump_valid   = 1'b0;
    jump_target  = '0;
    branch_valid = 1'b0;
    branch_imm   = '0;
    jr_valid     = 1'b0;
    jr_target    = '0;
    test_reset();
    test_jump();
    test_branch();
    test_stall();
    test_back_to_back();
    test_jr_priority();
    test_reset_pending();
    test_mis_in_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
